seg_display_scheduler: RTL and testbench

// Shares the 4-digit multiplexed seven-segment display between N_REQ requesters.

---
 rtl/seg_display_pkg.sv | 27 ++
 rtl/seg_display_scheduler_scan.sv | 45 ++++
 rtl/seg_display_scheduler.sv | 114 +++++++++++
 tb/tb_seg_display_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared constants, arbiter state type and round-robin helpers
// for the multiplexed seven-segment display scheduler.
package seg_display_pkg;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam int         DIGITS    = 4;

    typedef enum logic {ST_IDLE, ST_OWNED} arb_state_t;

    // Requests are zero-extended to 8 bits, so searching mod 8 visits the
    // real requesters in the same cyclic order as searching mod N_REQ.
    function automatic logic [7:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] idx;
        rr_pick = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = last + 3'(i) + 3'd1;
            if (r[idx]) rr_pick = 8'b1 << idx;
        end
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) oh2idx = 3'(i);
    endfunction

endpackage

// File: rtl/seg_display_scheduler_scan.sv
// seg_scan_timer: digit slot counter and frame pulse; exposes next-cycle slot
// and blank so the top can register its outputs in step with the scan.
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       CLK,
    input  logic       RESETN,
    output logic [1:0] o_slot_nxt,
    output logic       o_blank_nxt,
    output logic       o_frame_end
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_slot;
    logic          r_frame_end;
    logic          w_wrap;

    always_comb begin
        w_wrap      = r_cnt == CW'(SCAN_DIV - 1);
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
        o_slot_nxt  = w_wrap ? r_slot + 2'd1 : r_slot;
        o_blank_nxt = 32'(w_cnt_nxt) < BLANK_CYC;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt       <= '0;
            r_slot      <= '0;
            r_frame_end <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_slot      <= o_slot_nxt;
            r_frame_end <= o_slot_nxt == 2'(DIGITS - 1) && w_cnt_nxt == CW'(SCAN_DIV - 1);
        end
    end

    assign o_frame_end = r_frame_end;

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: frame-synchronous round-robin owner of a 4-digit
// multiplexed display, with minimum hold time and tear-free digit snapshots.
module seg_display_scheduler
    import seg_display_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int SCAN_DIV    = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_digits,
    input  logic [4*N_REQ-1:0]   req_dp,
    output logic [N_REQ-1:0]     grant,
    output logic [3:0]           an,
    output logic [3:0]           digit_val,
    output logic                 dp_n,
    output logic                 frame_end
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [2:0]       r_last, w_last_nxt;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    logic [15:0]      r_snap_d, w_snap_d_nxt, w_sel_d;
    logic [3:0]       r_snap_dp, w_snap_dp_nxt, w_sel_dp;
    logic [3:0]       r_an, r_digit, w_an_nxt;
    logic             r_dp_n;
    logic [1:0]       w_slot_nxt;
    logic             w_blank_nxt, w_frame_end;
    logic [7:0]       w_req8, w_pick;
    logic             w_owner_req, w_other_req, w_hold_done;

    seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .o_slot_nxt  (w_slot_nxt),
        .o_blank_nxt (w_blank_nxt),
        .o_frame_end (w_frame_end)
    );

    always_comb begin
        w_req8              = '0;
        w_req8[N_REQ-1:0]   = req;
        w_pick              = rr_pick(w_req8, r_last);
        w_owner_req         = |(req & r_grant);
        w_other_req         = |(req & ~r_grant);
        w_hold_done         = 32'(r_hold) + 1 >= HOLD_FRAMES;
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_last_nxt          = r_last;
        w_hold_nxt          = r_hold;
        if (w_frame_end) begin
            if (r_state == ST_IDLE || !w_owner_req || (w_other_req && w_hold_done)) begin
                w_grant_nxt = w_pick[N_REQ-1:0];
                w_hold_nxt  = '0;
                if (|w_pick) w_last_nxt = oh2idx(w_pick);
            end else begin
                w_hold_nxt  = w_hold_done ? HW'(HOLD_FRAMES) : r_hold + HW'(1);
            end
            w_state_nxt = |w_grant_nxt ? ST_OWNED : ST_IDLE;
        end
        w_sel_d  = '0;
        w_sel_dp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_nxt[i]) begin
                w_sel_d  = req_digits[16*i +: 16];
                w_sel_dp = req_dp[4*i +: 4];
            end
        end
        w_snap_d_nxt  = w_frame_end ? w_sel_d : r_snap_d;
        w_snap_dp_nxt = w_frame_end ? w_sel_dp : r_snap_dp;
        w_an_nxt      = (~|w_grant_nxt || w_blank_nxt) ? ANODE_OFF : ~(4'b0001 << w_slot_nxt);
    end

    // Outputs are computed from next-cycle scan/grant values so they line up with the counters.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= 3'd7;
            r_hold    <= '0;
            r_snap_d  <= '0;
            r_snap_dp <= '0;
            r_an      <= ANODE_OFF;
            r_digit   <= '0;
            r_dp_n    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_snap_d  <= w_snap_d_nxt;
            r_snap_dp <= w_snap_dp_nxt;
            r_an      <= w_an_nxt;
            r_digit   <= w_snap_d_nxt[4*w_slot_nxt +: 4];
            r_dp_n    <= (w_an_nxt == ANODE_OFF) | ~w_snap_dp_nxt[w_slot_nxt];
        end
    end

    assign grant     = r_grant;
    assign an        = r_an;
    assign digit_val = r_digit;
    assign dp_n      = r_dp_n;
    assign frame_end = w_frame_end;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: directed scenarios with hand-computed expectations
// (N_REQ=3, SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2; frame = 32 cycles).
module tb_seg_display_scheduler;

    logic        CLK;
    logic        RESETN;
    logic [2:0]  req;
    logic [15:0] d0, d1, d2;
    logic [3:0]  p0, p1, p2;
    logic [2:0]  grant;
    logic [3:0]  an;
    logic [3:0]  digit_val;
    logic        dp_n;
    logic        frame_end;
    int          n_pass;
    int          n_total;

    seg_display_scheduler #(
        .N_REQ       (3),
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .HOLD_FRAMES (2)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .req        (req),
        .req_digits ({d2, d1, d0}),
        .req_dp     ({p2, p1, p0}),
        .grant      (grant),
        .an         (an),
        .digit_val  (digit_val),
        .dp_n       (dp_n),
        .frame_end  (frame_end)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESETN = 1'b0;
        req = 3'b000;
        d0 = 16'h0000; d1 = 16'h0000; d2 = 16'h0000;
        p0 = 4'b0000; p1 = 4'b0000; p2 = 4'b0000;
        repeat (2) @(negedge CLK);
        n_total++; if (an !== 4'b1111) $display("FAIL reset_an got %b want 1111", an); else n_pass++;
        n_total++; if (grant !== 3'b000) $display("FAIL reset_grant got %b want 000", grant); else n_pass++;
        n_total++; if (digit_val !== 4'h0) $display("FAIL reset_digit got %h want 0", digit_val); else n_pass++;
        n_total++; if (dp_n !== 1'b1) $display("FAIL reset_dp_n got %b want 1", dp_n); else n_pass++;
        n_total++; if (frame_end !== 1'b0) $display("FAIL reset_frame_end got %b want 0", frame_end); else n_pass++;
        RESETN = 1'b1;
    endtask

    task automatic test_idle();
        int n, bad;
        bad = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n++;
            if (an !== 4'b1111 || grant !== 3'b000) bad++;
            if (frame_end === 1'b1) break;
        end
        n_total++; if (n !== 31) $display("FAIL idle_first_frame_end got %0d want 31", n); else n_pass++;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n++;
            if (an !== 4'b1111 || grant !== 3'b000) bad++;
            if (frame_end === 1'b1) break;
        end
        n_total++; if (n !== 32) $display("FAIL idle_frame_period got %0d want 32", n); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL idle_blank got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_single();
        logic [15:0] d;
        logic [3:0]  ea;
        logic        ed;
        int          s, c;
        d0 = 16'h1234;
        p0 = 4'b0101;
        req = 3'b001;
        d = 16'h1234;
        for (int p = 0; p < 32; p++) begin
            @(negedge CLK);
            s = p / 8;
            c = p % 8;
            ea = (c < 2) ? 4'b1111 : ~(4'b0001 << s);
            ed = (c < 2) ? 1'b1 : ~p0[s];
            n_total++; if (an !== ea) $display("FAIL single_an p=%0d got %b want %b", p, an, ea); else n_pass++;
            n_total++; if (digit_val !== d[4*s +: 4]) $display("FAIL single_digit p=%0d got %h want %h", p, digit_val, d[4*s +: 4]); else n_pass++;
            n_total++; if (dp_n !== ed) $display("FAIL single_dp_n p=%0d got %b want %b", p, dp_n, ed); else n_pass++;
            if (p == 0) begin
                n_total++; if (grant !== 3'b001) $display("FAIL single_grant got %b want 001", grant); else n_pass++;
                n_total++; if (frame_end !== 1'b0) $display("FAIL single_fe_start got %b want 0", frame_end); else n_pass++;
            end
            if (p == 31) begin
                n_total++; if (frame_end !== 1'b1) $display("FAIL single_fe_end got %b want 1", frame_end); else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] eg [8];
        logic [3:0] ev [8];
        int         bad;
        eg = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
        ev = '{4'h4, 4'h8, 4'h8, 4'hC, 4'hC, 4'h4, 4'h4, 4'h8};
        d1 = 16'h5678;
        d2 = 16'h9ABC;
        req = 3'b111;
        for (int f = 0; f < 8; f++) begin
            bad = 0;
            for (int p = 0; p < 32; p++) begin
                @(negedge CLK);
                if (p == 0) begin
                    n_total++; if (grant !== eg[f]) $display("FAIL rr_grant f=%0d got %b want %b", f, grant, eg[f]); else n_pass++;
                end else if (grant !== eg[f]) bad++;
                if (p == 2) begin
                    n_total++; if (digit_val !== ev[f]) $display("FAIL rr_digit f=%0d got %h want %h", f, digit_val, ev[f]); else n_pass++;
                    n_total++; if (an !== 4'b1110) $display("FAIL rr_an f=%0d got %b want 1110", f, an); else n_pass++;
                end
                if (p == 31) begin
                    n_total++; if (frame_end !== 1'b1) $display("FAIL rr_fe f=%0d got %b want 1", f, frame_end); else n_pass++;
                end
            end
            n_total++; if (bad !== 0) $display("FAIL rr_stable f=%0d got %0d changes want 0", f, bad); else n_pass++;
        end
    endtask

    task automatic test_owner_drop();
        req = 3'b001;
        for (int p = 0; p < 32; p++) begin
            @(negedge CLK);
            if (p == 0) begin
                n_total++; if (grant !== 3'b001) $display("FAIL drop_grant0 got %b want 001", grant); else n_pass++;
            end
            if (p == 12) req = 3'b100;
            if (p == 18) begin
                n_total++; if (digit_val !== 4'h2) $display("FAIL drop_digit_s2 got %h want 2", digit_val); else n_pass++;
            end
            if (p == 26) begin
                n_total++; if (digit_val !== 4'h1) $display("FAIL drop_digit_s3 got %h want 1", digit_val); else n_pass++;
                n_total++; if (an !== 4'b0111) $display("FAIL drop_an_s3 got %b want 0111", an); else n_pass++;
            end
            if (p == 31) begin
                n_total++; if (grant !== 3'b001) $display("FAIL drop_grant_hold got %b want 001", grant); else n_pass++;
            end
        end
        for (int p = 0; p < 32; p++) begin
            @(negedge CLK);
            if (p == 0) begin
                n_total++; if (grant !== 3'b100) $display("FAIL drop_grant_new got %b want 100", grant); else n_pass++;
            end
            if (p == 2) begin
                n_total++; if (digit_val !== 4'hC) $display("FAIL drop_digit_new got %h want c", digit_val); else n_pass++;
            end
        end
    endtask

    task automatic test_data_change();
        logic [15:0] d;
        d = 16'hABCD;
        req = 3'b001;
        for (int p = 0; p < 32; p++) begin
            @(negedge CLK);
            if (p == 0) begin
                n_total++; if (grant !== 3'b001) $display("FAIL data_grant got %b want 001", grant); else n_pass++;
            end
            if (p == 12) d0 = 16'hABCD;
            if (p == 18) begin
                n_total++; if (digit_val !== 4'h2) $display("FAIL data_old_s2 got %h want 2", digit_val); else n_pass++;
            end
            if (p == 26) begin
                n_total++; if (digit_val !== 4'h1) $display("FAIL data_old_s3 got %h want 1", digit_val); else n_pass++;
            end
        end
        for (int p = 0; p < 32; p++) begin
            @(negedge CLK);
            if (p % 8 == 2) begin
                n_total++; if (digit_val !== d[4*(p/8) +: 4]) $display("FAIL data_new p=%0d got %h want %h", p, digit_val, d[4*(p/8) +: 4]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        for (int p = 0; p < 20; p++) @(negedge CLK);
        n_total++; if (an !== 4'b1011) $display("FAIL rst_pre_an got %b want 1011", an); else n_pass++;
        RESETN = 1'b0;
        #1;
        n_total++; if (an !== 4'b1111) $display("FAIL rst_mid_an got %b want 1111", an); else n_pass++;
        n_total++; if (grant !== 3'b000) $display("FAIL rst_mid_grant got %b want 000", grant); else n_pass++;
        n_total++; if (digit_val !== 4'h0) $display("FAIL rst_mid_digit got %h want 0", digit_val); else n_pass++;
        n_total++; if (dp_n !== 1'b1) $display("FAIL rst_mid_dp_n got %b want 1", dp_n); else n_pass++;
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        bad = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n++;
            if (grant !== 3'b000 || an !== 4'b1111) bad++;
            if (frame_end === 1'b1) break;
        end
        n_total++; if (n !== 31) $display("FAIL rst_restart got %0d want 31", n); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL rst_idle got %0d bad cycles want 0", bad); else n_pass++;
        @(negedge CLK);
        n_total++; if (grant !== 3'b001) $display("FAIL rst_regrant got %b want 001", grant); else n_pass++;
        repeat (2) @(negedge CLK);
        n_total++; if (an !== 4'b1110) $display("FAIL rst_slot0_an got %b want 1110", an); else n_pass++;
        n_total++; if (digit_val !== 4'hD) $display("FAIL rst_slot0_digit got %h want d", digit_val); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_owner_drop();
        test_data_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
